// File: rtl/tia_horizontal_decode.sv
// Horizontal timing decoder driven by the TIA horizontal LFSR: sync, blank,
// colour burst, line-start/LFSR-reset pulses and the WSYNC/RDY CPU halt.
module tia_horizontal_decode #(
  parameter logic [5:0] LINE_END        = 6'b010100,
  parameter logic [5:0] HSYNC_SET       = 6'b111100,
  parameter logic [5:0] HSYNC_RST       = 6'b110111,
  parameter logic [5:0] CB_SET          = 6'b110111,
  parameter logic [5:0] CB_RST          = 6'b001111,
  parameter logic [5:0] HBLANK_RST      = 6'b011100,
  parameter logic [5:0] LATE_HBLANK_RST = 6'b010111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] lfsr,
  input  logic       lfsr_step,
  input  logic       hmove,
  input  logic       wsync,
  output logic       lfsr_reset,
  output logic       line_start,
  output logic       hsync,
  output logic       hblank,
  output logic       color_burst,
  output logic       rdy
);

  localparam logic [5:0] LOCKUP = 6'b111111;

  logic late;
  logic waiting;

  logic hit_line_end;
  logic hit_hsync_set;
  logic hit_hsync_rst;
  logic hit_cb_set;
  logic hit_cb_rst;
  logic hit_hblank_rst;
  logic hit_late_rst;

  logic hsync_n;
  logic cb_n;
  logic hblank_n;
  logic late_n;
  logic waiting_n;

  // State decodes, qualified by the LFSR advance pulse.
  always_comb begin
    hit_line_end   = lfsr_step && ((lfsr == LINE_END) || (lfsr == LOCKUP));
    hit_hsync_set  = lfsr_step && (lfsr == HSYNC_SET);
    hit_hsync_rst  = lfsr_step && (lfsr == HSYNC_RST);
    hit_cb_set     = lfsr_step && (lfsr == CB_SET);
    hit_cb_rst     = lfsr_step && (lfsr == CB_RST);
    hit_hblank_rst = lfsr_step && (lfsr == HBLANK_RST) && !late;
    hit_late_rst   = lfsr_step && (lfsr == LATE_HBLANK_RST) && late;
  end

  // Next values; strobes win over same-cycle clears so they carry into the next line.
  always_comb begin
    hsync_n   = hsync;
    cb_n      = color_burst;
    hblank_n  = hblank;
    late_n    = late;
    waiting_n = waiting;

    if (hit_hsync_set) hsync_n = 1'b1;
    if (hit_hsync_rst) hsync_n = 1'b0;
    if (hit_cb_set)    cb_n    = 1'b1;
    if (hit_cb_rst)    cb_n    = 1'b0;

    if (hit_line_end)                   hblank_n = 1'b1;
    if (hit_hblank_rst || hit_late_rst) hblank_n = 1'b0;

    if (hit_late_rst) late_n = 1'b0;
    if (hmove)        late_n = 1'b1;

    if (hit_line_end) waiting_n = 1'b0;
    if (wsync)        waiting_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync       <= 1'b0;
      color_burst <= 1'b0;
      hblank      <= 1'b1;
      rdy         <= 1'b1;
      lfsr_reset  <= 1'b0;
      line_start  <= 1'b0;
      late        <= 1'b0;
      waiting     <= 1'b0;
    end else begin
      hsync       <= hsync_n;
      color_burst <= cb_n;
      hblank      <= hblank_n;
      rdy         <= !waiting_n;
      lfsr_reset  <= hit_line_end;
      line_start  <= hit_line_end;
      late        <= late_n;
      waiting     <= waiting_n;
    end
  end

endmodule
